// File: rtl/oka_pkg.sv
// Shared types and default widths for the sequential Karatsuba GF(2)[x] multiplier.
// The top and core take N as a parameter; these localparams describe the default N=5 build.
package oka_pkg;

  localparam int N_DEF = 5;
  localparam int OPW   = 2 * N_DEF;
  localparam int PW    = 2 * N_DEF - 1;
  localparam int YW    = 4 * N_DEF - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_LO  = 3'd1,
    S_HI  = 3'd2,
    S_MID = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/gf2_mul_core.sv
// Combinational N x N carry-less multiplier built from one Karatsuba level.
// The operands split into a ceil(N/2)-bit low half and a zero-extended high half.
module gf2_mul_core #(
  parameter int N = 5
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-2:0] y
);

  localparam int M = (N + 1) / 2;

  function automatic logic [2*M-2:0] clmul_m(input logic [M-1:0] x, input logic [M-1:0] z);
    logic [2*M-2:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      if (z[i]) r = r ^ ((2*M-1)'(x) << i);
    end
    return r;
  endfunction

  logic [M-1:0]   a_lo, a_hi, b_lo, b_hi;
  logic [2*M-2:0] p_lo, p_hi, p_mid;

  assign a_lo = a[M-1:0];
  assign b_lo = b[M-1:0];
  assign a_hi = M'(a[N-1:M]);
  assign b_hi = M'(b[N-1:M]);

  assign p_lo  = clmul_m(a_lo, b_lo);
  assign p_hi  = clmul_m(a_hi, b_hi);
  assign p_mid = clmul_m(a_lo ^ a_hi, b_lo ^ b_hi);

  // The true product has degree 2N-2, so every term fits once cast to 2N-1 bits.
  assign y = ((2*N-1)'(p_hi) << (2*M))
           ^ ((2*N-1)'(p_lo ^ p_hi ^ p_mid) << M)
           ^ (2*N-1)'(p_lo);

endmodule

// File: rtl/oka_seq_mul_ctrl.sv
// Sequential Karatsuba controller: one shared N-bit core computes P0, P1 and PM over
// three cycles, then the assembled (4N-1)-bit product is offered behind valid/ready.
module oka_seq_mul_ctrl
  import oka_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-2:0] y,
  output logic           busy
);

  state_t         state;
  logic [2*N-1:0] op_a, op_b;
  logic [2*N-2:0] p0, p1;
  logic [N-1:0]   core_a, core_b;
  logic [2*N-2:0] core_y;
  logic [2*N-2:0] mid_term;
  logic [4*N-2:0] y_next;

  // Core operand mux: low halves, high halves, or the half-sums for PM.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    core_a = op_a[N-1:0] ^ op_a[2*N-1:N];
    core_b = op_b[N-1:0] ^ op_b[2*N-1:N];
    case (state)
      S_LO: begin
        core_a = op_a[N-1:0];
        core_b = op_b[N-1:0];
      end
      S_HI: begin
        core_a = op_a[2*N-1:N];
        core_b = op_b[2*N-1:N];
      end
      default: ;
    endcase
  end

  gf2_mul_core #(.N(N)) u_core (
    .a (core_a),
    .b (core_b),
    .y (core_y)
  );

  // In S_MID the core output is PM.
  assign mid_term = p0 ^ p1 ^ core_y;
  assign y_next   = ((4*N-1)'(p1) << (2*N))
                  ^ ((4*N-1)'(mid_term) << N)
                  ^ (4*N-1)'(p0);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y         <= '0;
      op_a      <= '0;
      op_b      <= '0;
      p0        <= '0;
      p1        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= b;
            state    <= S_LO;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_LO: begin
          p0    <= core_y;
          state <= S_HI;
        end
        S_HI: begin
          p1    <= core_y;
          state <= S_MID;
        end
        S_MID: begin
          y         <= y_next;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // No accept here even if out_ready is high: the next op starts from IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oka_seq_mul_ctrl.sv
// Scoreboard bench for oka_seq_mul_ctrl (N=5): the driver pushes expected products,
// an independent monitor pops and compares on every output transfer.
module tb_oka_seq_mul_ctrl;
  import oka_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  a = '0;
  logic [9:0]  b = '0;
  logic        in_ready, out_valid, busy;
  logic [18:0] y;

  int          checks = 0;
  int          failures = 0;
  int          n_issued = 0;
  int          n_results = 0;
  logic [18:0] sb[$];
  bit          hold_prev = 1'b0;
  logic [18:0] y_prev = '0;
  bit          done = 1'b0;

  oka_seq_mul_ctrl #(.N(N_DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Schoolbook carry-less product: bit i+j of the result collects a[i]&b[j].
  function automatic logic [18:0] clmul_ref(input logic [9:0] x, input logic [9:0] z);
    logic [18:0] r;
    r = '0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        r[i+j] = r[i+j] ^ (x[i] & z[j]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [9:0] ia, input logic [9:0] ib, input logic [18:0] exp);
    bit acc = 1'b0;
    int waited = 0;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      tick();
      waited++;
    end
    if (acc) begin
      sb.push_back(exp);
      n_issued++;
    end else begin
      check("issue_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  // Monitor: compares every transfer with the scoreboard and checks hold stability.
  always @(negedge clk) begin
    logic [18:0] exp;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_y", 32'(y), 32'(y_prev));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("result_y", 32'(y), 32'(exp));
          n_results++;
        end
      end
      hold_prev = out_valid && !out_ready;
      y_prev    = y;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] ra, rb;
    int waited;

    // Reset state
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Latency: out_valid rises three edges after the accepting edge
    issue(10'h3FF, 10'h001, 19'h003FF);
    @(negedge clk);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_3_edges", 32'(out_valid), 32'd1);
    tick();

    // Boundary products
    issue(10'h200, 10'h200, 19'h40000);
    issue(10'h003, 10'h003, 19'h00005);

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("bp_y", 32'(y), 32'h5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
      in_valid = (i % 2 == 0);
      a = 10'($urandom);
      b = 10'($urandom);
      @(negedge clk);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    tick();

    // Operands change after accept; only the latched pair counts
    ra = 10'($urandom_range(1, 1023));
    rb = 10'($urandom_range(1, 1023));
    issue(ra, rb, clmul_ref(ra, rb));
    for (int i = 0; i < 6; i++) begin
      a = 10'($urandom);
      b = 10'($urandom);
      tick();
    end

    // Reset in S_HI discards the operation
    ra = 10'($urandom);
    rb = 10'($urandom);
    out_ready = 1'b0;
    issue(ra, rb, clmul_ref(ra, rb));
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    n_issued -= sb.size();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b1;
    issue(10'h155, 10'h0AA, clmul_ref(10'h155, 10'h0AA));

    // Random back-to-back traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          ra = 10'($urandom);
          rb = 10'($urandom);
          issue(ra, rb, clmul_ref(ra, rb));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join

    out_ready = 1'b1;
    waited = 0;
    while ((sb.size() != 0 || busy) && waited < 50) begin
      tick();
      waited++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("result_count", 32'(n_results), 32'(n_issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
